// File: rtl/tail_light_pkg.sv
// Shared types and constants for the tail-light lamp sequencer.
package tail_light_pkg;

  // Sequencer FSM states
  typedef enum logic [1:0] {
    StIdle,
    StRamp,
    StHold
  } state_e;

  // Side select encodings fed to the light mux
  localparam logic [1:0] SIDE_NONE  = 2'b00;
  localparam logic [1:0] SIDE_RIGHT = 2'b01;
  localparam logic [1:0] SIDE_LEFT  = 2'b10;
  localparam logic [1:0] SIDE_BOTH  = 2'b11;

  // Brightness table; wider duty words zero-extend L0..L2 and saturate L3
  localparam logic [7:0] LEVEL_0 = 8'h03;
  localparam logic [7:0] LEVEL_1 = 8'h0F;
  localparam logic [7:0] LEVEL_2 = 8'h3F;
  localparam logic [7:0] LEVEL_3 = 8'hFF;

  localparam int unsigned NUM_LAMPS  = 3;
  localparam int unsigned NUM_LEVELS = 4;

endpackage

// File: rtl/tail_light_tick.sv
// Ramp-step prescaler: emits a one-cycle step pulse every TICK_DIV enabled cycles.
// A synchronous clear holds the count at zero.
module tail_light_tick #(
  parameter int unsigned TICK_DIV = 6250000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic clr_i,
  output logic step_o
);

  localparam int unsigned   CntW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            wrap;

  assign wrap   = (cnt_q == CntMax);
  assign step_o = en_i & ~clr_i & wrap;

  // Next count: clear wins, otherwise count and wrap at the end of a step
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
    end
  end

  // Count register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tail_light_sequencer.sv
// Tail-light sequencer: on a turn request, latch the side and ramp lamps 0..2 through
// four brightness levels, hold all lamps full for one step, then blank.
// Build option: define TAIL_LIGHT_HAZARD_EN to let left&right start a sequence on both sides.
module tail_light_sequencer
  import tail_light_pkg::*;
#(
  parameter int unsigned TICK_DIV = 6250000,
  parameter int unsigned DUTY_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              left,
  input  logic              right,
  output logic [DUTY_W-1:0] duty_0,
  output logic [DUTY_W-1:0] duty_1,
  output logic [DUTY_W-1:0] duty_2,
  output logic [1:0]        side,
  output logic              busy
);

  localparam logic [1:0] LastLamp  = 2'(NUM_LAMPS - 1);
  localparam logic [1:0] LastLevel = 2'(NUM_LEVELS - 1);

  state_e                           state_q, state_d;
  logic [1:0]                       lamp_q, lamp_d;
  logic [1:0]                       level_q, level_d;
  logic [1:0]                       side_q, side_d;
  logic [NUM_LAMPS-1:0][DUTY_W-1:0] duty_q, duty_d;
  logic                             step;
  logic                             start;
  logic [1:0]                       req_side;
  logic                             tick_en;
  logic                             tick_clr;

  function automatic logic [DUTY_W-1:0] level_duty(input logic [1:0] lvl);
    logic [DUTY_W-1:0] d;
    case (lvl)
      2'd0:    d = DUTY_W'(LEVEL_0);
      2'd1:    d = DUTY_W'(LEVEL_1);
      2'd2:    d = DUTY_W'(LEVEL_2);
      default: d = '1;
    endcase
    return d;
  endfunction

  // Prescaler only runs during a sequence and sits at zero while idle
  assign tick_en  = (state_q != StIdle);
  assign tick_clr = (state_q == StIdle);

  tail_light_tick #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk_i (clk),
    .rst_ni(reset),
    .en_i  (tick_en),
    .clr_i (tick_clr),
    .step_o(step)
  );

  // Decode a start request and the side it selects
  always_comb begin
    start    = 1'b0;
    req_side = SIDE_NONE;
    if (left ^ right) begin
      start    = 1'b1;
      req_side = right ? SIDE_RIGHT : SIDE_LEFT;
    end
`ifdef TAIL_LIGHT_HAZARD_EN
    else if (left && right) begin
      start    = 1'b1;
      req_side = SIDE_BOTH;
    end
`endif
  end

  // State, position and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      lamp_q  <= '0;
      level_q <= '0;
      side_q  <= SIDE_NONE;
      duty_q  <= '0;
    end else begin
      state_q <= state_d;
      lamp_q  <= lamp_d;
      level_q <= level_d;
      side_q  <= side_d;
      duty_q  <= duty_d;
    end
  end

  // Next state: requests are only looked at in idle, so the side stays latched
  always_comb begin
    state_d = state_q;
    lamp_d  = lamp_q;
    level_d = level_q;
    side_d  = side_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRamp;
          lamp_d  = '0;
          level_d = '0;
          side_d  = req_side;
        end
      end
      StRamp: begin
        if (step) begin
          if (level_q == LastLevel) begin
            level_d = '0;
            if (lamp_q == LastLamp) begin
              state_d = StHold;
            end else begin
              lamp_d = lamp_q + 2'd1;
            end
          end else begin
            level_d = level_q + 2'd1;
          end
        end
      end
      StHold: begin
        if (step) begin
          state_d = StIdle;
          lamp_d  = '0;
          level_d = '0;
          side_d  = SIDE_NONE;
        end
      end
      default: begin
        state_d = StIdle;
        lamp_d  = '0;
        level_d = '0;
        side_d  = SIDE_NONE;
      end
    endcase
  end

  // Next duty words: only the lamp being ramped changes; finished lamps keep full brightness
  always_comb begin
    duty_d = duty_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          duty_d    = '0;
          duty_d[0] = level_duty(2'd0);
        end
      end
      StRamp: begin
        if (step) begin
          for (int i = 0; i < int'(NUM_LAMPS); i++) begin
            if (level_q == LastLevel) begin
              if (lamp_q == LastLamp) begin
                duty_d[i] = '1;
              end else if (2'(i) == lamp_q + 2'd1) begin
                duty_d[i] = level_duty(2'd0);
              end
            end else if (2'(i) == lamp_q) begin
              duty_d[i] = level_duty(level_q + 2'd1);
            end
          end
        end
      end
      StHold: begin
        if (step) begin
          duty_d = '0;
        end
      end
      default: begin
        duty_d = '0;
      end
    endcase
  end

  assign duty_0 = duty_q[0];
  assign duty_1 = duty_q[1];
  assign duty_2 = duty_q[2];
  assign side   = side_q;
  assign busy   = (state_q != StIdle);

endmodule

// File: tb/tb_tail_light_sequencer.sv
// Bench for tail_light_sequencer with TICK_DIV=4: a per-cycle comparison against a
// timeline model plus literal spot checks from hand-worked sequences.
module tb_tail_light_sequencer;

  localparam int TD    = 4;
  localparam int STEPS = 13;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic       left  = 1'b0;
  logic       right = 1'b0;
  logic [7:0] duty_0, duty_1, duty_2;
  logic [1:0] side;
  logic       busy;
  logic [26:0] obs;

  int  n_cmp   = 0;
  int  n_bad   = 0;
  int  cur     = 0;
  bit  run_cmp = 1'b0;

  // Model: whether a sequence is running, cycles since its start edge, latched side
  bit         m_active = 1'b0;
  int         m_k      = 0;
  logic [1:0] m_side   = 2'b00;

  tail_light_sequencer #(
    .TICK_DIV(TD),
    .DUTY_W  (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .left  (left),
    .right (right),
    .duty_0(duty_0),
    .duty_1(duty_1),
    .duty_2(duty_2),
    .side  (side),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  assign obs = {duty_0, duty_1, duty_2, side, busy};

  function automatic bit req_start(input logic l, input logic r);
`ifdef TAIL_LIGHT_HAZARD_EN
    return l | r;
`else
    return l ^ r;
`endif
  endfunction

  // Expected outputs from position in the sequence: step = elapsed / TD
  function automatic logic [26:0] model_out(input bit act, input int k, input logic [1:0] sd);
    logic [7:0] tab [4];
    logic [7:0] d   [3];
    int st, lamp, lvl;
    tab = '{8'h03, 8'h0F, 8'h3F, 8'hFF};
    if (!act) return '0;
    st = k / TD;
    for (int j = 0; j < 3; j++) d[j] = 8'h00;
    if (st >= 12) begin
      for (int j = 0; j < 3; j++) d[j] = 8'hFF;
    end else begin
      lamp = st / 4;
      lvl  = st % 4;
      for (int j = 0; j < 3; j++) begin
        if (j < lamp)       d[j] = 8'hFF;
        else if (j == lamp) d[j] = tab[lvl];
      end
    end
    return {d[0], d[1], d[2], sd, 1'b1};
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_active <= 1'b0;
      m_k      <= 0;
      m_side   <= 2'b00;
    end else if (!m_active) begin
      if (req_start(left, right)) begin
        m_active <= 1'b1;
        m_k      <= 0;
        m_side   <= {left, right};
      end
    end else if (m_k + 1 >= STEPS * TD) begin
      m_active <= 1'b0;
      m_side   <= 2'b00;
    end else begin
      m_k <= m_k + 1;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t: got %h, want %h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (run_cmp) check("model", 32'(obs), 32'(model_out(m_active, m_k, m_side)));
  end

  task automatic begin_scn();
    @(negedge clk);
    cur = 0;
  endtask

  task automatic step_to(input int c);
    while (cur < c) begin
      @(negedge clk);
      cur++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    #12;
    check("reset_state", 32'(obs), 32'h0);
    @(negedge clk);
    reset   = 1'b1;
    run_cmp = 1'b1;
    step_to(2);

    // Right pulse of one cycle
    begin_scn();
    right = 1'b1;
    step_to(1);
    right = 1'b0;
    check("r_c1", 32'({duty_0, side, busy}), {21'h0, 8'h03, 2'b01, 1'b1});
    step_to(4);
    check("r_c4_d0", 32'(duty_0), 32'h03);
    step_to(5);
    check("r_c5_d0", 32'(duty_0), 32'h0F);
    step_to(13);
    check("r_c13_d0", 32'(duty_0), 32'hFF);
    step_to(17);
    check("r_c17", 32'(obs), 32'({8'hFF, 8'h03, 8'h00, 2'b01, 1'b1}));
    step_to(45);
    check("r_c45_d2", 32'(duty_2), 32'hFF);
    step_to(49);
    check("r_c49", 32'(obs), 32'({8'hFF, 8'hFF, 8'hFF, 2'b01, 1'b1}));
    step_to(52);
    check("r_c52", 32'(obs), 32'({8'hFF, 8'hFF, 8'hFF, 2'b01, 1'b1}));
    step_to(53);
    check("r_c53_idle", 32'(obs), 32'h0);
    step_to(56);

    // Left held continuously: immediate restart after the one idle cycle
    begin_scn();
    left = 1'b1;
    step_to(30);
    check("lh_c30_side", 32'(side), 32'h2);
    step_to(53);
    check("lh_c53_idle", 32'(obs), 32'h0);
    step_to(54);
    check("lh_c54", 32'(obs), 32'({8'h03, 8'h00, 8'h00, 2'b10, 1'b1}));
    left = 1'b0;
    step_to(110);
    check("lh_end_idle", 32'(busy), 32'h0);

    // Left start, right pulse mid-sequence is ignored
    begin_scn();
    left = 1'b1;
    step_to(1);
    left = 1'b0;
    step_to(10);
    right = 1'b1;
    step_to(11);
    right = 1'b0;
    step_to(20);
    check("lr_c20", 32'(obs), 32'({8'hFF, 8'h03, 8'h00, 2'b10, 1'b1}));
    step_to(53);
    check("lr_c53_idle", 32'(obs), 32'h0);
    step_to(56);

    // Asynchronous reset between clock edges mid-sequence
    begin_scn();
    left = 1'b1;
    step_to(1);
    left = 1'b0;
    step_to(22);
    check("ar_c22_busy", 32'(busy), 32'h1);
    #1 reset = 1'b0;
    #1 check("ar_async", 32'(obs), 32'h0);
    step_to(24);
    reset = 1'b1;
    step_to(34);
    check("ar_after", 32'(obs), 32'h0);

    // Both requests at once
    begin_scn();
    left  = 1'b1;
    right = 1'b1;
    step_to(1);
    left  = 1'b0;
    right = 1'b0;
`ifdef TAIL_LIGHT_HAZARD_EN
    check("both_c1", 32'(obs), 32'({8'h03, 8'h00, 8'h00, 2'b11, 1'b1}));
`else
    check("both_c1", 32'(obs), 32'h0);
`endif
    step_to(56);
    check("both_end", 32'(busy), 32'h0);

    run_cmp = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tail_light_sequencer.md
Name: tail_light_sequencer

Overview:
Controller that sequences the three PWM tail-lamp channels of the dimmed tail-light design. On a turn request it latches the side and ramps lamp 0, then lamp 1, then lamp 2 through four brightness levels. It holds all three lamps at full brightness for one step, then blanks them. Outputs are registered duty words and a side select that feed existing external PWM instances and the light mux.

Parameters:
TICK_DIV, 6250000, clk cycles per ramp step (125 ms at 50 MHz); legal range >= 1
DUTY_W, 8, duty word width

Ports:
clk        input   1       system clock, all state on rising edge
reset      input   1       asynchronous, active-low reset
left       input   1       left turn request, level
right      input   1       right turn request, level
duty_0     output  DUTY_W  duty of lamp 0 (innermost)
duty_1     output  DUTY_W  duty of lamp 1
duty_2     output  DUTY_W  duty of lamp 2 (outermost)
side       output  2       00 none, 01 right, 10 left, 11 both
busy       output  1       high while a sequence runs

Behaviour:
- Reset (reset=0, async): state IDLE, prescaler 0, lamp index 0, level 0. duty_0/1/2=0, side=00, busy=0. Outputs change immediately, not on the next clk edge. This applies also mid-sequence.
- Level table: L0=0x03, L1=0x0F, L2=0x3F, L3=0xFF (zero-extended/low bits set for wider DUTY_W; all ones for L3).
- FSM states: IDLE, RAMP, HOLD.
- IDLE -> RAMP:
  - On the edge where left^right=1.
  - Latch side (right -> 01, left -> 10).
  - Lamp=0, level=0, prescaler=0.
  - Next cycle: duty_0=L0, busy=1.
- RAMP step timing: prescaler counts 0..TICK_DIV-1. At TICK_DIV-1 it wraps to 0 and advances the step.
- RAMP step advance:
  - Level increments.
  - On level 3 -> 0, the lamp index increments.
  - The current lamp's duty takes table[level].
  - Completed lamps stay at 0xFF; lamps not yet reached stay at 0.
- RAMP -> HOLD: after lamp 2 level 3 completes its step. In HOLD all duties=0xFF for one step.
- HOLD -> IDLE: at the end of the step. duties=0, side=00, busy=0.
- Latency: the first duty is visible 1 cycle after the request is sampled. Total sequence is 13*TICK_DIV cycles; IDLE is reached at cycle 13*TICK_DIV+1.
- left/right are ignored while busy. Mid-sequence changes or releases do not abort and do not alter side.
- A request still held when IDLE is re-entered starts a new sequence on that edge. IDLE lasts exactly 1 cycle.
- left=right=1 in IDLE: no start (but see the optional feature).
- TICK_DIV=1: every RAMP/HOLD step lasts 1 cycle.
- The prescaler is held at 0 in IDLE.

Optional Feature:
TAIL_LIGHT_HAZARD_EN:
- Defined: left&right in IDLE starts a sequence with side=11. The same ramp is driven to both banks by the downstream mux.
- Undefined: left&right is treated as no request, and side never takes 11.

Decomposition:
- Package tail_light_pkg holds:
  - state enum (IDLE, RAMP, HOLD)
  - side encodings SIDE_NONE/RIGHT/LEFT/BOTH
  - level constants LEVEL_0..LEVEL_3
  - number of lamps (3) and levels (4)
- One sub-module, tail_light_tick: prescaler with enable and synchronous clear that emits a 1-cycle step pulse every TICK_DIV cycles. Same async active-low reset.

Test Plan:
All scenarios use TICK_DIV=4; cycle 0 is the edge where the request is sampled.
- Right pulse of 1 cycle at cycle 0:
  - Cycles 1-4: side=01, busy=1, duty_0=0x03.
  - Cycles 5-8: duty_0=0x0F.
  - Cycles 13-16: duty_0=0xFF.
  - Cycles 17-20: duty_1=0x03.
  - Cycles 45-48: duty_2=0xFF.
  - Cycles 49-52: all 0xFF.
  - Cycle 53: all 0, busy=0.
- Left held continuously: side=10 for the whole sequence. Second sequence starts on the edge at cycle 53; duty_0=0x03 at cycle 54.
- Left at cycle 0, then right pulses at cycle 10: side stays 10 and the sequence is unchanged.
- reset=0 asserted between clk edges at cycle 22:
  - duties/side/busy go to 0 with no clock edge.
  - After release with no request, outputs remain 0.
- left=right=1 at cycle 0:
  - Without macro: busy stays 0 and duties stay 0.
  - With TAIL_LIGHT_HAZARD_EN: side=11 and duty_0=0x03 at cycle 1.
